ff_negedge_deser_rx: RTL and testbench
======================================

// Module: ff_negedge_deser_rx
// PURPOSE
//   Capture side of the negedge-launch serial link. The transmitter launches one
//   bit per clk falling edge; this block samples on the rising edge, half a cycle
//   later, and assembles MSB-first words. Completed words go into a small output
//   FIFO with a valid/ready handshake. It is the posedge-capture counterpart used
//   in the seq/ff techmap simulation tests.
// PARAMETERS
//   WIDTH   8   bits per word; legal range 2..32
//   DEPTH   2   output FIFO entries; legal values 2 or 4
// PORTS
//   clk       in   1      single clock; every state element updates on posedge clk
//   rst_n     in   1      asynchronous active-low reset
//   sin       in   1      serial data, launched on negedge clk by the transmitter
//   sin_vld   in   1      sin carries a valid bit this cycle
//   sync      in   1      marks the first (MSB) bit of a word; qualified by sin_vld
//   out_rdy   in   1      consumer accepts out_data this cycle
//   out_data  out  WIDTH  FIFO head word
//   out_vld   out  1      FIFO not empty
//   busy      out  1      FSM is in SHIFT state
//   frame_err out  1      sticky: sync seen mid-word
//   overflow  out  1      sticky: word dropped because the FIFO was full
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//   - FSM goes to IDLE; bit count, shift register and FIFO pointers clear.
//   - out_data=0, out_vld=0, busy=0, frame_err=0, overflow=0.
//   - Reset mid-word discards the partial word and all FIFO contents.
//   Sampling:
//   - sin, sin_vld and sync are sampled on posedge only.
//   - sync without sin_vld is ignored.
//   FSM IDLE:
//   - sin_vld & sync: shreg = {.., sin}, cnt=1, go to SHIFT.
//   - Anything else: stay in IDLE; bits that arrive without sync are discarded.
//   FSM SHIFT:
//   - sin_vld=0: stall; shreg and cnt hold, with no timeout.
//   - sin_vld=1 & sync=0: shreg = {shreg[WIDTH-2:0], sin}, cnt++.
//   - sin_vld=1 & sync=1: set frame_err; drop the partial word; restart with this
//     bit as MSB, cnt=1; stay in SHIFT.
//   - When the sampled bit makes cnt==WIDTH: push the word and go to IDLE, cnt=0.
//     A sync on the completing cycle counts as mid-word: frame_err is set and the
//     word is not pushed.
//   FIFO / handshake:
//   - Pop occurs when out_vld & out_rdy.
//   - out_data and out_vld are registered. A pushed word is visible on the cycle
//     after its last bit is sampled, giving 1-cycle latency from the last bit.
//   - out_data holds stable while out_vld=1 & out_rdy=0.
//   - Push when full with no pop: the word is dropped, overflow is set, FIFO is
//     unchanged.
//   - Push when full with a simultaneous pop: both occur, nothing is dropped.
//   - Push into an empty FIFO with out_rdy=1: the word still appears for at least
//     one cycle; there is no combinational bypass.
//   - Pointers wrap modulo DEPTH; occupancy is tracked with a DEPTH+1-state count.
//   - frame_err and overflow clear only on reset.
// TESTING
//   1. WIDTH=8, sync+bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles, out_rdy=1
//      -> out_vld=1 for one cycle, 1 cycle after the 8th bit, out_data=8'hA5.
//   2. Same frame with sin_vld=0 for 3 cycles after bit 4
//      -> busy stays 1 through the stall; out_data=8'hA5; no error flags.
//   3. 3 back-to-back frames 8'h11, 8'h22, 8'h33, out_rdy=0, DEPTH=2
//      -> FIFO holds 8'h11, 8'h22; overflow=1; pops then yield 8'h11 and 8'h22.
//   4. sync re-asserted at bit 5 of a word, then 7 more bits of 8'h3C
//      -> frame_err=1; only 8'h3C is delivered.
//   5. Full FIFO with out_rdy=1 on the cycle a 3rd word completes
//      -> no overflow; order 1st, 2nd, 3rd is preserved.
//   6. rst_n pulsed low mid-word with out_vld=1
//      -> all outputs 0 immediately; the next clean frame is received correctly.

Source files
------------

// File: rtl/ff_negedge_deser_rx_if.sv
// Signal bundle for the negedge-launch serial receive link and its output word stream.
interface ff_negedge_deser_rx_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             sin_vld;
  logic             sync;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_vld;
  logic             busy;
  logic             frame_err;
  logic             overflow;

  modport master (
    output sin, sin_vld, sync, out_rdy,
    input  out_data, out_vld, busy, frame_err, overflow
  );

  modport slave (
    input  sin, sin_vld, sync, out_rdy,
    output out_data, out_vld, busy, frame_err, overflow
  );
endinterface

// File: rtl/ff_negedge_deser_rx.sv
// Posedge capture of a negedge-launched MSB-first serial stream, assembling words
// into a small valid/ready output FIFO with sticky framing and overflow flags.
module ff_negedge_deser_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ff_negedge_deser_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-2:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             push, ferr_set, ferr;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    occ;
  logic             ovf, vld, full, pop, do_push;

  // shreg keeps only the WIDTH-1 bits already received; the bit on sin completes the word
  assign word = {shreg, bus.sin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      ferr  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      if (ferr_set) ferr <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.sin_vld && bus.sync) begin
          shreg_nxt    = '0;
          shreg_nxt[0] = bus.sin;
          cnt_nxt      = CW'(1);
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_vld) begin
          if (bus.sync) begin
            // mid-word sync wins even on the completing bit: restart instead of pushing
            ferr_set     = 1'b1;
            shreg_nxt    = '0;
            shreg_nxt[0] = bus.sin;
            cnt_nxt      = CW'(1);
          end else if (cnt == CW'(WIDTH - 1)) begin
            push      = 1'b1;
            shreg_nxt = word[WIDTH-2:0];
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            shreg_nxt = word[WIDTH-2:0];
            cnt_nxt   = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  assign vld     = (occ != '0);
  assign full    = (occ == OW'(DEPTH));
  assign pop     = vld && bus.out_rdy;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && full && !pop) ovf <= 1'b1;
      case ({do_push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_vld   = vld;
  assign bus.busy      = (state == SHIFT);
  assign bus.frame_err = ferr;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_ff_negedge_deser_rx.sv
// Randomized and directed bench for ff_negedge_deser_rx against a word-level queue model.
module tb_ff_negedge_deser_rx;
  localparam int W = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ff_negedge_deser_rx_if #(.WIDTH(W)) bus ();

  ff_negedge_deser_rx #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word-level reference: bits accumulate arithmetically, the FIFO is a queue.
  bit [W-1:0]  m_q[$];
  bit [W-1:0]  delivered[$];
  bit          m_in, m_ferr, m_ovf, m_pop, m_push;
  int          m_n;
  int unsigned m_acc;
  bit [W-1:0]  m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_in = 0; m_n = 0; m_acc = 0; m_ferr = 0; m_ovf = 0;
    end else begin
      m_pop  = (m_q.size() != 0) && bus.out_rdy;
      m_push = 0;
      if (bus.sin_vld) begin
        if (bus.sync) begin
          if (m_in) m_ferr = 1;
          m_in = 1; m_n = 1; m_acc = int'(bus.sin);
        end else if (m_in) begin
          m_acc = m_acc * 2 + int'(bus.sin);
          m_n++;
          if (m_n == W) begin
            m_push = 1; m_word = m_acc[W-1:0]; m_in = 0; m_n = 0;
          end
        end
      end
      if (m_pop) delivered.push_back(m_q.pop_front());
      if (m_push) begin
        if (m_q.size() < D) m_q.push_back(m_word);
        else m_ovf = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_vld", 32'(bus.out_vld), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
      chk("busy", 32'(bus.busy), 32'(m_in));
      chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  task automatic drive(input logic s, input logic v, input logic y, input logic r);
    @(negedge clk);
    bus.sin = s; bus.sin_vld = v; bus.sync = y; bus.out_rdy = r;
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic rdy, input logic rdy_last,
                           input int stall_at, input int stall_len);
    for (int i = W - 1; i >= 0; i--) begin
      drive(v[i], 1'b1, i == W - 1, (i == 0) ? rdy_last : rdy);
      if (stall_at != 0 && (W - i) == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          drive(1'b0, 1'b0, 1'b0, rdy);
          chk("stall_busy", 32'(bus.busy), 32'd1);
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_out_vld"}, 32'(bus.out_vld), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sin = 0; bus.sin_vld = 0; bus.sync = 0; bus.out_rdy = 0;
    rst_n = 1'b0;
    #1 chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    delivered.delete();
  endtask

  initial begin
    bus.sin = 0; bus.sin_vld = 0; bus.sync = 0; bus.out_rdy = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;

    // 1: single frame A5 with consumer ready
    send_word(8'hA5, 1'b1, 1'b1, 0, 0);
    drive(0, 0, 0, 1);
    chk("t1_vld", 32'(bus.out_vld), 32'd1);
    chk("t1_data", 32'(bus.out_data), 32'hA5);
    drive(0, 0, 0, 1);
    chk("t1_vld_drop", 32'(bus.out_vld), 32'd0);
    chk("t1_log", 32'(delivered.size() == 1 && delivered[0] == 8'hA5), 32'd1);

    // 2: stall of 3 cycles after bit 4
    do_reset();
    send_word(8'hA5, 1'b0, 1'b0, 4, 3);
    drive(0, 0, 0, 0);
    chk("t2_data", 32'(bus.out_data), 32'hA5);
    chk("t2_ferr", 32'(bus.frame_err), 32'd0);
    chk("t2_ovf", 32'(bus.overflow), 32'd0);

    // 3: three frames into a 2-deep FIFO with no consumer
    do_reset();
    send_word(8'h11, 0, 0, 0, 0);
    send_word(8'h22, 0, 0, 0, 0);
    send_word(8'h33, 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    chk("t3_head", 32'(bus.out_data), 32'h11);
    drive(0, 0, 0, 1);
    chk("t3_hold", 32'(bus.out_data), 32'h11);
    drive(0, 0, 0, 1);
    chk("t3_second", 32'(bus.out_data), 32'h22);
    drive(0, 0, 0, 0);
    chk("t3_empty", 32'(bus.out_vld), 32'd0);
    chk("t3_log", 32'(delivered.size() == 2 && delivered[0] == 8'h11 && delivered[1] == 8'h22), 32'd1);

    // 4: sync re-asserted at bit 5, then 3C
    do_reset();
    drive(1, 1, 1, 1); drive(1, 1, 0, 1); drive(0, 1, 0, 1); drive(1, 1, 0, 1);
    send_word(8'h3C, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 1);
    chk("t4_ferr", 32'(bus.frame_err), 32'd1);
    chk("t4_log", 32'(delivered.size() == 1 && delivered[0] == 8'h3C), 32'd1);

    // 5: full FIFO popped on the cycle the 3rd word completes
    do_reset();
    send_word(8'h5A, 0, 0, 0, 0);
    send_word(8'hC3, 0, 0, 0, 0);
    send_word(8'h96, 0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 1);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    chk("t5_log", 32'(delivered.size() == 3 && delivered[0] == 8'h5A &&
                      delivered[1] == 8'hC3 && delivered[2] == 8'h96), 32'd1);

    // 6: asynchronous reset mid-word while out_vld=1
    do_reset();
    send_word(8'h81, 0, 0, 0, 0);
    drive(1, 1, 1, 0); drive(0, 1, 0, 0); drive(1, 1, 0, 0);
    @(negedge clk);
    bus.sin = 0; bus.sin_vld = 0; bus.sync = 0;
    chk("t6_vld_before", 32'(bus.out_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    delivered.delete();
    send_word(8'h7E, 1, 1, 0, 0);
    drive(0, 0, 0, 1);
    chk("t6_data", 32'(bus.out_data), 32'h7E);
    chk("t6_vld", 32'(bus.out_vld), 32'd1);

    // randomized traffic, checked every cycle by the compare process
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(1)), $urandom_range(99) < 75, $urandom_range(99) < 10,
            $urandom_range(99) < 50);
    end
    repeat (4) drive(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
